pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage core.
- Consumes hazard sources from ID, EX and MEM and drives the en/flush pairs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Owns the multi-cycle mul/div stall sequencer and a stall-cycle performance counter.

Parameters:
DIV_CYCLES, 8, EX-stall cycles per mul/div op; legal range 2..255
CNT_W, 8, width of the internal mul/div countdown counter; must hold DIV_CYCLES-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX destination register
ex_rd_we  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
ex_redirect  in  1  EX branch/jump taken, PC redirect
ex_mdiv  in  1  EX holds a mul/div op
ex_trap  in  1  EX raised trap or interrupt
mem_wait  in  1  MEM data access not yet complete
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register flushes (flush wins over en in the register)
mdiv_busy  out  1  high while in MDIV state
mdiv_done  out  1  one-cycle pulse on mul/div release cycle
stall_cycles  out  32  saturating count of cycles with pc_en=0

Behaviour:
- Sequential state: FSM {RUN, MDIV}, countdown cnt[CNT_W], stall_cycles. All cleared asynchronously on rst: RUN, cnt=0, stall_cycles=0.
- Outputs are combinational from state, cnt and inputs.
- While rst is high: all en=0, all flush=0, mdiv_busy=0, mdiv_done=0.
- Default (no hazard): all en=1, all flush=0.
- Load-use hazard (lu) is true when all of the following hold:
  - ex_is_load & ex_rd_we & ex_rd!=0
  - (id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)
- Per-cycle priority, highest first:
  1. ex_trap: if_id_flush=id_ex_flush=ex_mem_flush=1; pc_en=1, mem_wb_en=1. Aborts MDIV: next state RUN, cnt=0, no mdiv_done. Overrides mem_wait, because the trapping instruction never enters MEM.
  2. mem_wait: all en=0; mem_wb_flush=1 (bubble into WB, no double writeback); other flushes 0. The cnt update rule still applies.
  3. MDIV stall (state MDIV with cnt!=0, or state RUN with ex_mdiv): pc_en=if_id_en=id_ex_en=0; ex_mem_flush=1; mem_wb_en=1.
  4. ex_redirect: if_id_flush=id_ex_flush=1; pc_en=1; masks lu.
  5. lu: pc_en=if_id_en=0; id_ex_flush=1; ex_mem_en=mem_wb_en=1.
- FSM transitions:
  - RUN & ex_mdiv & ~ex_trap: go to MDIV, cnt=DIV_CYCLES-1. Entry happens even under mem_wait.
  - MDIV & cnt!=0: cnt decrements every cycle, including mem_wait cycles. cnt holds at 0.
  - MDIV & cnt==0 & ~mem_wait & ~ex_trap: release cycle.
    - mdiv_done=1, mdiv_busy=1.
    - Outputs follow rules 4/5/default.
    - Next state RUN.
    - ex_mdiv (still high this cycle) is ignored, so there is no retrigger.
  - MDIV & cnt==0 & mem_wait: remain in MDIV, no mdiv_done.
- Stall length: a mul/div with no other hazards holds pc_en=0 for exactly DIV_CYCLES cycles; the release follows on the next cycle.
- stall_cycles: +1 on every cycle with pc_en=0 outside reset; saturates at 32'hFFFF_FFFF.
- Reset mid-MDIV: immediate return to RUN, cnt=0; outputs forced per the reset rule.

Test Plan:
1. Reset release, idle inputs -> all en=1, flush=0, stall_cycles=0, mdiv_busy=0.
2. ex_is_load=1, ex_rd_we=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 for 1 cycle -> pc_en=if_id_en=0, id_ex_flush=1, stall_cycles=1. Repeat with ex_rd=0 -> no stall.
3. ex_mdiv held, DIV_CYCLES=8 -> pc_en=0 and ex_mem_flush=1 for 8 cycles, mdiv_done on the 9th cycle with all en=1, stall_cycles=8. Same test with mem_wait high for 3 cycles at cnt==0 -> release delayed 3 cycles.
4. lu and ex_redirect in the same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, no stall counted.
5. ex_trap in the 4th MDIV cycle -> if/id/ex_mem flushes=1, next cycle mdiv_busy=0, no mdiv_done. ex_trap together with mem_wait -> trap outputs win.
6. Assert rst asynchronously mid-clock during MDIV -> outputs go to reset values before the next edge. Force stall_cycles near max -> it holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the 5-stage core datapath and the hazard/pipeline-control
// unit.
//
// Hazard sources (core -> control):
//   id_rs1, id_rs2, id_uses_rs1, id_uses_rs2   ID-stage operand usage
//   ex_rd, ex_rd_we, ex_is_load                EX-stage destination info
//   ex_redirect, ex_mdiv, ex_trap              EX-stage events
//   mem_wait                                   MEM access outstanding
//
// Pipeline control (control -> core):
//   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en     register enables
//   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush register flushes
//   mdiv_busy, mdiv_done                                mul/div sequencer
//   stall_cycles                                        stall perf counter
//
// Modports:
//   master : the control unit (consumes hazards, drives enables/flushes)
//   slave  : the core datapath (drives hazards, consumes enables/flushes)
// ----------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        ex_is_load;
  logic        ex_redirect;
  logic        ex_mdiv;
  logic        ex_trap;
  logic        mem_wait;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        mem_wb_flush;
  logic        mdiv_busy;
  logic        mdiv_done;
  logic [31:0] stall_cycles;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_rd_we, ex_is_load, ex_redirect, ex_mdiv, ex_trap,
    input  mem_wait,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    output mdiv_busy, mdiv_done, stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_rd_we, ex_is_load, ex_redirect, ex_mdiv, ex_trap,
    output mem_wait,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
    input  mdiv_busy, mdiv_done, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Hazard and pipeline-control unit for the 5-stage core. Resolves load-use,
// redirect, trap, memory-wait and multi-cycle mul/div hazards into en/flush
// pairs for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers, and keeps
// a saturating count of cycles in which the PC was held.
//
// Parameters:
//   DIV_CYCLES : EX-stall cycles per mul/div op (2..255)
//   CNT_W      : countdown width, must hold DIV_CYCLES-1
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pipe_ctrl_if.master (hazard inputs, enable/flush/status outputs)
// ----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);

  if (DIV_CYCLES < 2 || DIV_CYCLES > 255 ||
      (DIV_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("pipe_ctrl: DIV_CYCLES out of range or CNT_W too narrow");
  end

  typedef enum logic {
    RUN  = 1'b0,
    MDIV = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nx;
  logic [31:0]      stall_cnt;

  logic lu;
  logic mdiv_stall;
  logic mdiv_release;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic ex_mem_en;
  logic mem_wb_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mem_wb_flush;
  logic mdiv_busy;
  logic mdiv_done;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Load in EX whose result is needed by the instruction in ID. x0 never
  // creates a dependency.
  assign lu = bus.ex_is_load && bus.ex_rd_we && (bus.ex_rd != 5'd0) &&
              ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
               (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // The first stall cycle is the RUN cycle in which the op shows up in EX;
  // the countdown then covers the remaining DIV_CYCLES-1 cycles.
  assign mdiv_stall   = ((state_q == MDIV) && (cnt_q != '0)) ||
                        ((state_q == RUN) && bus.ex_mdiv);
  assign mdiv_release = (state_q == MDIV) && (cnt_q == '0) &&
                        !bus.mem_wait && !bus.ex_trap;

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // ---- next state ----------------------------------------------------------
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    if (bus.ex_trap) begin
      state_nx = RUN;
      cnt_nx   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.ex_mdiv) begin
            state_nx = MDIV;
            cnt_nx   = CNT_W'(DIV_CYCLES - 1);
          end
        end
        MDIV: begin
          // Countdown keeps running through mem_wait; only the release
          // itself waits for MEM to complete.
          if (cnt_q != '0) begin
            cnt_nx = cnt_q - CNT_W'(1);
          end else if (!bus.mem_wait) begin
            state_nx = RUN;
          end
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // ---- enable / flush resolution -------------------------------------------
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdiv_busy    = (state_q == MDIV);
    mdiv_done    = mdiv_release;

    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      mdiv_busy = 1'b0;
      mdiv_done = 1'b0;
    end else if (bus.ex_trap) begin
      // The trapping instruction never reaches MEM, so mem_wait is moot.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (bus.mem_wait) begin
      // Freeze everything; WB gets a bubble so the MEM instruction is
      // written back only once, when it finally completes.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mdiv_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
    end else if (bus.ex_redirect) begin
      // Wrong-path instructions in IF/ID and ID are squashed, which also
      // makes any load-use dependency on them irrelevant.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // ---- stall performance counter -------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en) begin
      stall_cnt <= sat_inc32(stall_cnt);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mdiv_busy    = mdiv_busy;
  assign bus.mdiv_done    = mdiv_done;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (DIV_CYCLES=8). Each cycle the expected
// output vector is pushed to a scoreboard queue as stimulus is applied, then
// popped and compared mid-cycle. Output vector packing:
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
//    mdiv_busy, mdiv_done}
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int DIVC = 8;

  localparam logic [10:0] O_RST      = 11'b00000_0000_00;
  localparam logic [10:0] O_DEF      = 11'b11111_0000_00;
  localparam logic [10:0] O_LU       = 11'b00111_0100_00;
  localparam logic [10:0] O_RED      = 11'b11111_1100_00;
  localparam logic [10:0] O_MDV_RUN  = 11'b00011_0010_00;
  localparam logic [10:0] O_MDV      = 11'b00011_0010_10;
  localparam logic [10:0] O_WAIT_B   = 11'b00000_0001_10;
  localparam logic [10:0] O_REL      = 11'b11111_0000_11;
  localparam logic [10:0] O_REL_LU   = 11'b00111_0100_11;
  localparam logic [10:0] O_TRAP     = 11'b11111_1110_00;
  localparam logic [10:0] O_TRAP_B   = 11'b11111_1110_10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  logic [31:0] exp_stall = 32'd0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [10:0] exp;
  } lu_vec_t;

  function automatic logic [10:0] cur_obs();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
            bus.mdiv_busy, bus.mdiv_done};
  endfunction

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic clear_inputs();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_uses_rs1 = 1'b0;
    bus.id_uses_rs2 = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_rd_we    = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_mdiv     = 1'b0;
    bus.ex_trap     = 1'b0;
    bus.mem_wait    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    bus.ex_is_load  = 1'b1;
    bus.ex_rd_we    = 1'b1;
    bus.ex_rd       = r;
    bus.id_uses_rs2 = 1'b1;
    bus.id_rs2      = r;
  endtask

  // Entered and left at posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    clear_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (cur_obs() !== O_RST) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", cur_obs(), O_RST);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(O_DEF);
    #3;
    e = exp_q.pop_front();
    checks++;
    if (cur_obs() !== e) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", cur_obs(), e);
    end
    checks++;
    if (bus.stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles: got %0d expected 0", bus.stall_cycles);
    end
    tick();
  endtask

  task automatic test_load_use();
    lu_vec_t tab[6] = '{
      '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, O_LU },
      '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, O_DEF},
      '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, O_DEF},
      '{5'd9, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, O_LU },
      '{5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, O_DEF},
      '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, O_DEF}
    };
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      bus.id_rs1      = tab[i].rs1;
      bus.id_rs2      = tab[i].rs2;
      bus.id_uses_rs1 = tab[i].u1;
      bus.id_uses_rs2 = tab[i].u2;
      bus.ex_rd       = tab[i].rd;
      bus.ex_rd_we    = tab[i].we;
      bus.ex_is_load  = tab[i].ld;
      exp_q.push_back(tab[i].exp);
      if (!tab[i].exp[10]) exp_stall = sat32(exp_stall);
      #3;
      e = exp_q.pop_front();
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL load_use row %0d: got %b expected %b", i, cur_obs(), e);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL load_use_stall_cycles: got %0d expected %0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_mdiv(input int wait_cycles);
    logic [10:0] e;
    int n = DIVC + wait_cycles + 2;
    for (int c = 0; c < n; c++) begin
      clear_inputs();
      if (c < DIVC) begin
        bus.ex_mdiv = 1'b1;
        exp_q.push_back((c == 0) ? O_MDV_RUN : O_MDV);
      end else if (c < DIVC + wait_cycles) begin
        bus.ex_mdiv  = 1'b1;
        bus.mem_wait = 1'b1;
        exp_q.push_back(O_WAIT_B);
      end else if (c == DIVC + wait_cycles) begin
        bus.ex_mdiv = 1'b1;
        exp_q.push_back(O_REL);
      end else begin
        exp_q.push_back(O_DEF);
      end
      #3;
      e = exp_q.pop_front();
      if (!e[10]) exp_stall = sat32(exp_stall);
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL mdiv wait=%0d cycle %0d: got %b expected %b", wait_cycles, c, cur_obs(), e);
      end
      tick();
    end
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL mdiv_stall_cycles wait=%0d: got %0d expected %0d", wait_cycles, bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_redirect_lu();
    logic [10:0] e;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      if (c == 0) set_lu(5'd12);
      bus.ex_redirect = 1'b1;
      exp_q.push_back(O_RED);
      #3;
      e = exp_q.pop_front();
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL redirect_lu cycle %0d: got %b expected %b", c, cur_obs(), e);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL redirect_stall_cycles: got %0d expected %0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_trap();
    logic [10:0] e;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      case (c)
        0: begin bus.ex_mdiv = 1'b1; exp_q.push_back(O_MDV_RUN); end
        1, 2: begin bus.ex_mdiv = 1'b1; exp_q.push_back(O_MDV); end
        3: begin bus.ex_mdiv = 1'b1; bus.ex_trap = 1'b1; exp_q.push_back(O_TRAP_B); end
        4: exp_q.push_back(O_DEF);
        5: begin bus.ex_trap = 1'b1; bus.mem_wait = 1'b1; exp_q.push_back(O_TRAP); end
        6: begin
          bus.ex_trap = 1'b1; bus.mem_wait = 1'b1; bus.ex_mdiv = 1'b1;
          exp_q.push_back(O_TRAP);
        end
        default: exp_q.push_back(O_DEF);
      endcase
      #3;
      e = exp_q.pop_front();
      if (!e[10]) exp_stall = sat32(exp_stall);
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL trap cycle %0d: got %b expected %b", c, cur_obs(), e);
      end
      tick();
    end
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL trap_stall_cycles: got %0d expected %0d", bus.stall_cycles, exp_stall);
    end
  endtask

  // Release cycle carrying a load-use, then an immediate second op with a
  // mem_wait in the middle of its countdown (length must not change).
  task automatic test_back_to_back();
    logic [10:0] e;
    int n = 2 * DIVC + 3;
    for (int c = 0; c < n; c++) begin
      clear_inputs();
      if (c < DIVC) begin
        bus.ex_mdiv = 1'b1;
        exp_q.push_back((c == 0) ? O_MDV_RUN : O_MDV);
      end else if (c == DIVC) begin
        bus.ex_mdiv = 1'b1;
        set_lu(5'd3);
        exp_q.push_back(O_REL_LU);
      end else if (c < 2 * DIVC + 1) begin
        bus.ex_mdiv = 1'b1;
        if (c == DIVC + 3) begin
          bus.mem_wait = 1'b1;
          exp_q.push_back(O_WAIT_B);
        end else begin
          exp_q.push_back((c == DIVC + 1) ? O_MDV_RUN : O_MDV);
        end
      end else if (c == 2 * DIVC + 1) begin
        bus.ex_mdiv = 1'b1;
        exp_q.push_back(O_REL);
      end else begin
        exp_q.push_back(O_DEF);
      end
      #3;
      e = exp_q.pop_front();
      if (!e[10]) exp_stall = sat32(exp_stall);
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, cur_obs(), e);
      end
      tick();
    end
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL back_to_back_stall_cycles: got %0d expected %0d", bus.stall_cycles, exp_stall);
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      bus.ex_mdiv = 1'b1;
      exp_q.push_back((c == 0) ? O_MDV_RUN : O_MDV);
      #3;
      e = exp_q.pop_front();
      checks++;
      if (cur_obs() !== e) begin
        errors++;
        $display("FAIL async_reset pre cycle %0d: got %b expected %b", c, cur_obs(), e);
      end
      tick();
    end
    // Mid-cycle, MDIV with countdown running.
    #2;
    rst = 1'b1;
    #1;
    exp_stall = 32'd0;
    checks++;
    if (cur_obs() !== O_RST) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b expected %b", cur_obs(), O_RST);
    end
    checks++;
    if (bus.stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_stall_cycles: got %0d expected 0", bus.stall_cycles);
    end
    tick();
    clear_inputs();
    rst = 1'b0;
    exp_q.push_back(O_DEF);
    #3;
    e = exp_q.pop_front();
    checks++;
    if (cur_obs() !== e) begin
      errors++;
      $display("FAIL async_reset_release: got %b expected %b", cur_obs(), e);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    #1;
    exp_stall = 32'hFFFF_FFFD;
    checks++;
    if (bus.stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL sat_preload: got %h expected %h", bus.stall_cycles, exp_stall);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      set_lu(5'd17);
      exp_stall = sat32(exp_stall);
      tick();
      checks++;
      if (bus.stall_cycles !== exp_stall) begin
        errors++;
        $display("FAIL sat cycle %0d: got %h expected %h", c, bus.stall_cycles, exp_stall);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_mdiv(0);
    test_mdiv(3);
    test_redirect_lu();
    test_trap();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
